// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: display_driver reads the front bank while the host
// writes or zero-fills the back bank; banks swap only at a frame boundary.
module display_framebuffer #(
  parameter int unsigned rows     = 8,
  parameter int unsigned columns  = 32,
  parameter int unsigned bitwidth = 10,
  localparam int unsigned Depth   = rows * columns,
  localparam int unsigned RowW    = $clog2(rows),
  localparam int unsigned ColW    = $clog2(columns),
  localparam int unsigned AddrW   = $clog2(Depth),
  // One spare code above the last word so out-of-range host addresses are expressible
  localparam int unsigned WrAddrW = $clog2(Depth + 1),
  localparam int unsigned PixW    = 3 * bitwidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RowW-1:0]    row,
  input  logic [ColW-1:0]    column,
  output logic [PixW-1:0]    pixel,
  input  logic               frame_complete,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WrAddrW-1:0] wr_addr,
  input  logic [PixW-1:0]    wr_data,
  output logic               wr_drop,
  input  logic               swap_req,
  output logic               swap_done,
  input  logic               clear_req,
  output logic               clear_done,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StClear, StSwapWait} state_e;

  state_e            state_q;
  logic              front_q;
  logic [AddrW-1:0]  clr_cnt_q;
  logic              wr_ready_q, wr_drop_q, swap_done_q, clear_done_q, busy_q;
  logic [PixW-1:0]   pixel_q;

  logic [PixW-1:0]   bank0 [Depth];
  logic [PixW-1:0]   bank1 [Depth];

  logic              wr_fire, wr_in_range;
  logic              bank_we, we0, we1;
  logic [AddrW-1:0]  rd_addr, bank_waddr;
  logic [PixW-1:0]   bank_wdata;

  always_comb begin
    // wr_ready_q is only ever high while in IDLE
    wr_fire     = wr_valid & wr_ready_q;
    wr_in_range = wr_addr < WrAddrW'(Depth);
    rd_addr     = AddrW'(row) * AddrW'(columns) + AddrW'(column);

    bank_we    = 1'b0;
    bank_waddr = wr_addr[AddrW-1:0];
    bank_wdata = wr_data;
    if (state_q == StClear) begin
      bank_we    = 1'b1;
      bank_waddr = clr_cnt_q;
      bank_wdata = '0;
    end else if (wr_fire && wr_in_range) begin
      bank_we = 1'b1;
    end
    // Writes always target the back bank
    we0 = bank_we & front_q;
    we1 = bank_we & ~front_q;
  end

  always_ff @(posedge clk) begin
    if (we0) bank0[bank_waddr] <= bank_wdata;
  end

  always_ff @(posedge clk) begin
    if (we1) bank1[bank_waddr] <= bank_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= front_q ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      front_q      <= 1'b0;
      clr_cnt_q    <= '0;
      wr_ready_q   <= 1'b0;
      wr_drop_q    <= 1'b0;
      swap_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_drop_q    <= wr_fire & ~wr_in_range;
      swap_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
      // Registered outputs track the state being entered at this edge
      wr_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (swap_req) begin
            state_q    <= StSwapWait;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == AddrW'(Depth - 1)) begin
            state_q      <= StIdle;
            clear_done_q <= 1'b1;
          end else begin
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StSwapWait: begin
          if (frame_complete) begin
            front_q     <= ~front_q;
            state_q     <= StIdle;
            swap_done_q <= 1'b1;
          end else begin
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pixel      = pixel_q;
  assign wr_ready   = wr_ready_q;
  assign wr_drop    = wr_drop_q;
  assign swap_done  = swap_done_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_framebuffer.sv
// Bench for display_framebuffer: a reference model of both banks feeds a read
// scoreboard; write vectors come from a table, corner cases are hand sequenced.
module tb_display_framebuffer;
  localparam int unsigned Rows     = 8;
  localparam int unsigned Columns  = 32;
  localparam int unsigned Bitwidth = 10;
  localparam int unsigned Depth    = Rows * Columns;
  localparam int unsigned PixW     = 3 * Bitwidth;
  localparam int unsigned WrAddrW  = $clog2(Depth + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         row = '0;
  logic [4:0]         column = '0;
  logic [PixW-1:0]    pixel;
  logic               frame_complete = 1'b0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [WrAddrW-1:0] wr_addr = '0;
  logic [PixW-1:0]    wr_data = '0;
  logic               wr_drop;
  logic               swap_req = 1'b0;
  logic               swap_done;
  logic               clear_req = 1'b0;
  logic               clear_done;
  logic               busy;

  display_framebuffer dut (
    .clk            (clk),
    .rst            (rst),
    .row            (row),
    .column         (column),
    .pixel          (pixel),
    .frame_complete (frame_complete),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_drop        (wr_drop),
    .swap_req       (swap_req),
    .swap_done      (swap_done),
    .clear_req      (clear_req),
    .clear_done     (clear_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            known;
    logic [PixW-1:0] val;
  } exp_t;

  typedef struct {
    int              addr;
    logic [PixW-1:0] data;
    logic            drop;
  } wvec_t;

  exp_t            exp_q[$];
  logic [PixW-1:0] mem [2][Depth];
  bit              mk  [2][Depth];
  bit              mfront;
  int              n_cmp, n_err;
  wvec_t           tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a);
    row    = 3'(a / Columns);
    column = 5'(a % Columns);
  endtask

  task automatic push_front_exp(input int a);
    exp_t e;
    e.known = mk[mfront][a];
    e.val   = mem[mfront][a];
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      if (e.known) check(name, 64'(pixel), 64'(e.val));
    end
  endtask

  task automatic model_wr(input int a, input logic [PixW-1:0] d);
    if (a < int'(Depth)) begin
      mem[!mfront][a] = d;
      mk[!mfront][a]  = 1'b1;
    end
  endtask

  task automatic rd(input int a, input string name);
    set_rd(a);
    push_front_exp(a);
    step();
    pop_check(name);
  endtask

  task automatic do_clear(input string name);
    int cnt;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      step();
    end
    check({name, " busy cycles"}, 64'(cnt), 64'(Depth));
    check({name, " clear_done"}, 64'(clear_done), 64'd1);
    step();
    check({name, " clear_done single"}, 64'(clear_done), 64'd0);
    for (int i = 0; i < int'(Depth); i++) begin
      mem[!mfront][i] = '0;
      mk[!mfront][i]  = 1'b1;
    end
  endtask

  // Requests a swap (optionally with a write in the same cycle), holds a read on
  // address a, waits dly cycles, then pulses frame_complete.
  task automatic do_swap(input int dly, input int a, input bit wv, input int wa,
                         input logic [PixW-1:0] wd, input string name);
    int bad;
    set_rd(a);
    swap_req = 1'b1;
    wr_valid = wv;
    wr_addr  = WrAddrW'(wa);
    wr_data  = wd;
    step();
    swap_req = 1'b0;
    wr_valid = 1'b0;
    if (wv) model_wr(wa, wd);
    bad = 0;
    for (int i = 0; i < dly; i++) begin
      if (busy !== 1'b1 || wr_ready !== 1'b0 || swap_done !== 1'b0) bad++;
      step();
    end
    check({name, " wait-state violations"}, 64'(bad), 64'd0);
    frame_complete = 1'b1;
    push_front_exp(a);
    step();
    frame_complete = 1'b0;
    mfront = !mfront;
    pop_check({name, " read at swap edge"});
    check({name, " swap_done"}, 64'(swap_done), 64'd1);
    check({name, " busy after swap"}, 64'(busy), 64'd0);
    check({name, " wr_ready after swap"}, 64'(wr_ready), 64'd1);
    push_front_exp(a);
    step();
    pop_check({name, " read after swap"});
    check({name, " swap_done single"}, 64'(swap_done), 64'd0);
  endtask

  initial begin
    int bad;
    n_cmp  = 0;
    n_err  = 0;
    mfront = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < int'(Depth); i++) mk[b][i] = 1'b0;

    tbl[0] = '{0,   30'h0AAAA555, 1'b0};
    tbl[1] = '{255, 30'h15555AAA, 1'b0};
    tbl[2] = '{200, 30'h12345678, 1'b0};
    tbl[3] = '{37,  30'h00C0FFEE, 1'b0};
    tbl[4] = '{256, 30'h3EEEEEEE, 1'b1};
    tbl[5] = '{1,   30'h3FFFFFFF, 1'b0};
    tbl[6] = '{511, 30'h3DDDDDDD, 1'b1};
    tbl[7] = '{32,  30'h00000001, 1'b0};
    tbl[8] = '{100, 30'h2ABCDEF0, 1'b0};

    // Reset held with clock running
    repeat (3) step();
    check("reset pixel", 64'(pixel), 64'd0);
    check("reset wr_ready", 64'(wr_ready), 64'd0);
    check("reset wr_drop", 64'(wr_drop), 64'd0);
    check("reset swap_done", 64'(swap_done), 64'd0);
    check("reset clear_done", 64'(clear_done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b1;
    #1;
    check("wr_ready before first edge", 64'(wr_ready), 64'd0);
    step();
    check("wr_ready after release", 64'(wr_ready), 64'd1);
    check("busy after release", 64'(busy), 64'd0);

    // Zero bank1, show it; fill bank0 with 1, clear it, show it and read all back
    do_clear("clear bank1");
    do_swap(5, 0, 1'b0, 0, '0, "swap to bank1");
    for (int i = 0; i < int'(Depth); i++) begin
      wr_valid = 1'b1;
      wr_addr  = WrAddrW'(i);
      wr_data  = 30'h1;
      step();
      model_wr(i, 30'h1);
    end
    wr_valid = 1'b0;
    do_clear("clear filled bank0");
    do_swap(5, 0, 1'b0, 0, '0, "swap to bank0");
    bad = 0;
    for (int i = 0; i < int'(Depth); i++) begin
      set_rd(i);
      step();
      if (pixel !== '0) bad++;
    end
    check("cleared bank nonzero words", 64'(bad), 64'd0);

    // Write with swap_req in the same cycle, frame_complete 100 cycles later
    do_swap(100, 37, 1'b1, 37, 30'h3FF00401, "write+swap");
    rd(37, "row1 col5 readback");

    // Table-driven writes into back bank (bank0), including out-of-range drops
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_addr  = WrAddrW'(tbl[i].addr);
      wr_data  = tbl[i].data;
      step();
      model_wr(tbl[i].addr, tbl[i].data);
      check($sformatf("wr_drop addr %0d", tbl[i].addr), 64'(wr_drop), 64'(tbl[i].drop));
    end
    wr_valid = 1'b0;
    step();
    check("wr_drop idle", 64'(wr_drop), 64'd0);
    do_swap(3, 0, 1'b0, 0, '0, "swap to table bank");
    for (int i = 0; i < 9; i++) begin
      if (!tbl[i].drop) rd(tbl[i].addr, $sformatf("table read addr %0d", tbl[i].addr));
    end

    // Mark bank1[200] distinct, show bank1, then abort a clear of bank0 with reset
    wr_valid = 1'b1;
    wr_addr  = WrAddrW'(200);
    wr_data  = 30'h0BADBEEF;
    step();
    wr_valid = 1'b0;
    model_wr(200, 30'h0BADBEEF);
    do_swap(3, 200, 1'b0, 0, '0, "swap to bank1 again");
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (100) step();
    check("busy mid clear", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort wr_ready", 64'(wr_ready), 64'd0);
    check("abort pixel", 64'(pixel), 64'd0);
    step();
    step();
    rst    = 1'b1;
    mfront = 1'b0;
    for (int i = 0; i < 128; i++) mk[0][i] = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (clear_done !== 1'b0 || swap_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("pulses after clear abort", 64'(bad), 64'd0);
    rd(200, "front after clear abort");

    // Reset while waiting for a swap cancels it
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("busy in swap wait", 64'(busy), 64'd1);
    repeat (20) step();
    rst = 1'b0;
    #1;
    check("swap abort busy", 64'(busy), 64'd0);
    step();
    rst = 1'b1;
    step();
    frame_complete = 1'b1;
    step();
    frame_complete = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (swap_done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    check("pulses after swap abort", 64'(bad), 64'd0);
    rd(200, "front after swap abort");
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
